// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and ALU issue bundle for the ALU reservation station.
interface alu_rs_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int ROB_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [ROB_W-1:0]  in_rob_tag;
  logic              in_a_rdy;
  logic              in_b_rdy;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [ROB_W-1:0]  in_a_tag;
  logic [ROB_W-1:0]  in_b_tag;
  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              alu_ena;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [ROB_W-1:0]  alu_rob_tag;

  modport master (
    output in_valid, in_op, in_rob_tag, in_a_rdy, in_b_rdy, in_a, in_b,
           in_a_tag, in_b_tag, cdb_valid, cdb_tag, cdb_data,
    input  in_ready, alu_ena, alu_op, alu_a, alu_b, alu_rob_tag
  );

  modport slave (
    input  in_valid, in_op, in_rob_tag, in_a_rdy, in_b_rdy, in_a, in_b,
           in_a_tag, in_b_tag, cdb_valid, cdb_tag, cdb_data,
    output in_ready, alu_ena, alu_op, alu_a, alu_b, alu_rob_tag
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds micro-ops until operands arrive via CDB, issues one per cycle.
// Define ALU_RS_AGE_PRIO_EN for oldest-first select (age matrix); default is lowest-index select.
module alu_rs #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int ROB_W  = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  alu_rs_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy, a_rdy, b_rdy, elig;
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];
  logic [ROB_W-1:0]  a_tag [DEPTH];
  logic [ROB_W-1:0]  b_tag [DEPTH];
  logic [DATA_W-1:0] a_val [DEPTH];
  logic [DATA_W-1:0] b_val [DEPTH];
  logic [IDX_W-1:0]  alloc_idx, sel_idx;
  logic              sel_vld, alloc, a_hit, b_hit;
  logic              alu_ena_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [ROB_W-1:0]  alu_rob_q;

  assign elig         = busy & a_rdy & b_rdy;
  assign bus.in_ready = ~&busy;
  assign alloc        = bus.in_valid & bus.in_ready & ~flush;
  assign a_hit        = bus.cdb_valid & ~bus.in_a_rdy & (bus.in_a_tag == bus.cdb_tag);
  assign b_hit        = bus.cdb_valid & ~bus.in_b_rdy & (bus.in_b_tag == bus.cdb_tag);

  assign bus.alu_ena     = alu_ena_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_rob_tag = alu_rob_q;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) alloc_idx = IDX_W'(i);
  end

`ifdef ALU_RS_AGE_PRIO_EN
  // age[i][j] set: entry j was allocated before entry i and is still live
  logic [DEPTH-1:0] age [DEPTH];

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (elig[i] && !(|(age[i] & elig))) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          if (sel_vld && sel_idx == IDX_W'(j))
            age[i][j] <= 1'b0;
          else if (alloc && alloc_idx == IDX_W'(i))
            age[i][j] <= busy[j];
    end
  end
`else
  always_comb begin
    sel_vld = |elig;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (elig[i]) sel_idx = IDX_W'(i);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      a_rdy     <= '0;
      b_rdy     <= '0;
      alu_ena_q <= 1'b0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_rob_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        a_tag[i] <= '0;
        b_tag[i] <= '0;
        a_val[i] <= '0;
        b_val[i] <= '0;
      end
    end else if (flush) begin
      busy      <= '0;
      alu_ena_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && bus.cdb_valid) begin
          if (!a_rdy[i] && a_tag[i] == bus.cdb_tag) begin
            a_val[i] <= bus.cdb_data;
            a_rdy[i] <= 1'b1;
          end
          if (!b_rdy[i] && b_tag[i] == bus.cdb_tag) begin
            b_val[i] <= bus.cdb_data;
            b_rdy[i] <= 1'b1;
          end
        end
      end
      alu_ena_q <= sel_vld;
      if (sel_vld) begin
        alu_op_q      <= op_q[sel_idx];
        alu_a_q       <= a_val[sel_idx];
        alu_b_q       <= b_val[sel_idx];
        alu_rob_q     <= rob_q[sel_idx];
        busy[sel_idx] <= 1'b0;
      end
      // the allocated slot is free, so it never collides with the issued or woken entries
      if (alloc) begin
        busy[alloc_idx]  <= 1'b1;
        op_q[alloc_idx]  <= bus.in_op;
        rob_q[alloc_idx] <= bus.in_rob_tag;
        a_tag[alloc_idx] <= bus.in_a_tag;
        b_tag[alloc_idx] <= bus.in_b_tag;
        a_rdy[alloc_idx] <= bus.in_a_rdy | a_hit;
        b_rdy[alloc_idx] <= bus.in_b_rdy | b_hit;
        a_val[alloc_idx] <= bus.in_a_rdy ? bus.in_a : bus.cdb_data;
        b_val[alloc_idx] <= bus.in_b_rdy ? bus.in_b : bus.cdb_data;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic against a slot/sequence model.
module tb_alu_rs;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int ROB_W  = 4;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_rs_if #(.DATA_W(DATA_W), .OP_W(OP_W), .ROB_W(ROB_W)) bus ();

  alu_rs #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W), .ROB_W(ROB_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    logic [3:0]  op;
    logic [3:0]  rob;
    bit          ar;
    bit          br;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  at;
    logic [3:0]  bt;
    int unsigned seq;
  } ent_t;

  ent_t        m [DEPTH];
  int unsigned seq_ctr;
  logic        e_ena;
  logic [3:0]  e_op;
  logic [3:0]  e_tag;
  logic [31:0] e_a;
  logic [31:0] e_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m[i].busy = 0; m[i].ar = 0; m[i].br = 0; m[i].seq = 0;
    end
    seq_ctr = 0;
    e_ena = 0; e_op = 0; e_tag = 0; e_a = 0; e_b = 0;
  endtask

  // One clock edge of the station: pick from pre-edge contents, then wake, issue, allocate.
  task automatic model_step();
    int pick = -1;
    int slot = -1;
    int n    = m_count();
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
      e_ena = 0;
      return;
    end
    for (int i = 0; i < DEPTH; i++)
      if (m[i].busy && m[i].ar && m[i].br) begin
`ifdef ALU_RS_AGE_PRIO_EN
        if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].busy) slot = i;
    if (bus.cdb_valid)
      for (int i = 0; i < DEPTH; i++)
        if (m[i].busy) begin
          if (!m[i].ar && m[i].at == bus.cdb_tag) begin m[i].a = bus.cdb_data; m[i].ar = 1; end
          if (!m[i].br && m[i].bt == bus.cdb_tag) begin m[i].b = bus.cdb_data; m[i].br = 1; end
        end
    if (pick >= 0) begin
      e_ena = 1; e_op = m[pick].op; e_tag = m[pick].rob; e_a = m[pick].a; e_b = m[pick].b;
      m[pick].busy = 0;
    end else begin
      e_ena = 0;
    end
    if (bus.in_valid && n < DEPTH) begin
      m[slot].busy = 1;
      m[slot].op   = bus.in_op;
      m[slot].rob  = bus.in_rob_tag;
      m[slot].at   = bus.in_a_tag;
      m[slot].bt   = bus.in_b_tag;
      m[slot].ar   = bus.in_a_rdy || (bus.cdb_valid && bus.cdb_tag == bus.in_a_tag);
      m[slot].br   = bus.in_b_rdy || (bus.cdb_valid && bus.cdb_tag == bus.in_b_tag);
      m[slot].a    = bus.in_a_rdy ? bus.in_a : bus.cdb_data;
      m[slot].b    = bus.in_b_rdy ? bus.in_b : bus.cdb_data;
      m[slot].seq  = seq_ctr;
      seq_ctr++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("in_ready", bus.in_ready, (m_count() < DEPTH) ? 1 : 0);
      check("alu_ena", bus.alu_ena, e_ena);
      check("alu_op", bus.alu_op, e_op);
      check("alu_a", bus.alu_a, e_a);
      check("alu_b", bus.alu_b, e_b);
      check("alu_rob_tag", bus.alu_rob_tag, e_tag);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [3:0] tag,
                        input bit ar, input logic [31:0] a, input logic [3:0] at,
                        input bit br, input logic [31:0] b, input logic [3:0] bt);
    bus.in_valid = 1; bus.in_op = op; bus.in_rob_tag = tag;
    bus.in_a_rdy = ar; bus.in_a = a; bus.in_a_tag = at;
    bus.in_b_rdy = br; bus.in_b = b; bus.in_b_tag = bt;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    bus.cdb_valid = 1; bus.cdb_tag = t; bus.cdb_data = d;
  endtask

  task automatic clear_in();
    bus.in_valid = 0; bus.cdb_valid = 0; flush = 0;
  endtask

  initial begin
    bus.in_op = 0; bus.in_rob_tag = 0; bus.in_a_rdy = 0; bus.in_b_rdy = 0;
    bus.in_a = 0; bus.in_b = 0; bus.in_a_tag = 0; bus.in_b_tag = 0;
    bus.cdb_tag = 0; bus.cdb_data = 0;
    clear_in();
    repeat (2) tick();
    rst_n = 1;
    tick();
    check("rst_ena", bus.alu_ena, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_a", bus.alu_a, 0);
    check("rst_tag", bus.alu_rob_tag, 0);

    // both operands ready: issue one cycle after acceptance
    set_in(OP_ADD, 4'd2, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0);
    tick(); clear_in();
    check("t1_no_issue_yet", bus.alu_ena, 0);
    tick();
    check("t1_ena", bus.alu_ena, 1);
    check("t1_op", bus.alu_op, OP_ADD);
    check("t1_a", bus.alu_a, 5);
    check("t1_b", bus.alu_b, 7);
    check("t1_tag", bus.alu_rob_tag, 2);
    check("t1_model_a", e_a, 5);
    tick();
    check("t1_ena_drop", bus.alu_ena, 0);
    check("t1_hold_a", bus.alu_a, 5);

    // b pending on tag 3, woken by CDB
    set_in(OP_SUB, 4'd4, 1, 32'd10, 4'd0, 0, 32'd0, 4'd3);
    tick(); clear_in();
    tick(); tick();
    check("t2_wait", bus.alu_ena, 0);
    cdb(4'd3, 32'd4);
    tick(); clear_in();
    check("t2_wake_edge", bus.alu_ena, 0);
    tick();
    check("t2_ena", bus.alu_ena, 1);
    check("t2_op", bus.alu_op, OP_SUB);
    check("t2_a", bus.alu_a, 10);
    check("t2_b", bus.alu_b, 4);
    check("t2_model_b", e_b, 4);
    tick();

    // allocate-time bypass
    set_in(OP_ADD, 4'd5, 0, 32'd0, 4'd6, 1, 32'd3, 4'd0);
    cdb(4'd6, 32'h55);
    tick(); clear_in();
    tick();
    check("t3_ena", bus.alu_ena, 1);
    check("t3_a", bus.alu_a, 32'h55);
    check("t3_tag", bus.alu_rob_tag, 5);
    tick();

    // fill all entries, 9th ignored, wake one
    for (int i = 0; i < DEPTH; i++) begin
      set_in(OP_ADD, 4'(i), 0, 32'd0, 4'(8 + i), 1, 32'(i), 4'd0);
      tick();
    end
    clear_in();
    check("t4_full", bus.in_ready, 0);
    set_in(OP_SUB, 4'd15, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0);
    tick(); clear_in();
    check("t4_still_full", bus.in_ready, 0);
    tick();
    check("t4_ninth_ignored", bus.alu_ena, 0);
    cdb(4'd11, 32'hAA);
    tick(); clear_in();
    tick();
    check("t4_ena", bus.alu_ena, 1);
    check("t4_tag", bus.alu_rob_tag, 3);
    check("t4_a", bus.alu_a, 32'hAA);
    check("t4_b", bus.alu_b, 3);
    check("t4_ready_again", bus.in_ready, 1);
    flush = 1;
    tick(); clear_in();

    // priority: X lands in slot 1, younger Y in slot 0, both woken together
    set_in(OP_ADD, 4'd1, 0, 32'd0, 4'd1, 1, 32'd0, 4'd0);
    tick();
    set_in(OP_ADD, 4'd7, 0, 32'd0, 4'd2, 1, 32'd0, 4'd0);
    tick(); clear_in();
    cdb(4'd1, 32'd1);
    tick(); clear_in();
    tick();
    check("t5_a_issue", bus.alu_rob_tag, 1);
    set_in(OP_SUB, 4'd9, 0, 32'd0, 4'd2, 1, 32'd0, 4'd0);
    tick(); clear_in();
    cdb(4'd2, 32'h22);
    tick(); clear_in();
    tick();
    check("t5_first_ena", bus.alu_ena, 1);
`ifdef ALU_RS_AGE_PRIO_EN
    check("t5_first", bus.alu_rob_tag, 7);
    tick();
    check("t5_second", bus.alu_rob_tag, 9);
`else
    check("t5_first", bus.alu_rob_tag, 9);
    tick();
    check("t5_second", bus.alu_rob_tag, 7);
`endif
    tick();

    // flush with 3 busy entries, one eligible
    set_in(OP_ADD, 4'd1, 0, 32'd0, 4'd5, 1, 32'd0, 4'd0);
    tick();
    set_in(OP_ADD, 4'd2, 0, 32'd0, 4'd7, 1, 32'd0, 4'd0);
    tick();
    set_in(OP_ADD, 4'd3, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0);
    tick(); clear_in();
    flush = 1;
    tick(); clear_in();
    check("t6_ena", bus.alu_ena, 0);
    check("t6_ready", bus.in_ready, 1);
    cdb(4'd5, 32'd1);
    tick(); clear_in();
    tick();
    check("t6_no_issue", bus.alu_ena, 0);

    // random traffic; the per-cycle compare process does the checking
    for (int c = 0; c < 2000; c++) begin
      bus.in_valid   = ($urandom_range(0, 99) < 60);
      bus.in_op      = 4'($urandom_range(0, 9));
      bus.in_rob_tag = 4'($urandom_range(0, 15));
      bus.in_a_rdy   = $urandom_range(0, 1) == 1;
      bus.in_b_rdy   = $urandom_range(0, 1) == 1;
      bus.in_a       = $urandom;
      bus.in_b       = $urandom;
      bus.in_a_tag   = 4'($urandom_range(0, 15));
      bus.in_b_tag   = 4'($urandom_range(0, 15));
      bus.cdb_valid  = ($urandom_range(0, 99) < 50);
      bus.cdb_tag    = 4'($urandom_range(0, 15));
      bus.cdb_data   = $urandom;
      flush          = ($urandom_range(0, 99) == 0);
      tick();
      if (c == 1000) begin
        #2;
        rst_n = 0;
        #1;
        check("arst_ena", bus.alu_ena, 0);
        check("arst_a", bus.alu_a, 0);
        check("arst_op", bus.alu_op, 0);
        check("arst_ready", bus.in_ready, 1);
        tick();
        rst_n = 1;
      end
    end
    clear_in();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station and issue scheduler for the integer ALU in the out-of-order core. It accepts decoded ALU micro-ops from dispatch and holds them until both operands are available. Operand values are captured by snooping the common data bus (CDB). Each cycle it issues at most one ready entry, through a registered interface, to the combinational ALU, which is keyed by ROB tag.

## Interface
Parameters:
- DEPTH, 8: number of entries (power of two, 2..16)
- DATA_W, 32: operand/result width
- OP_W, 4: ALU operation code width (same encoding as the ALU: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLTU, SLT)
- ROB_W, 4: ROB tag width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  mispredict flush, synchronous
- in_valid  in  1  dispatch offers a micro-op
- in_ready  out  1  a free entry exists (not full)
- in_op  in  OP_W  operation
- in_rob_tag  in  ROB_W  destination ROB tag
- in_a_rdy / in_b_rdy  in  1  operand value already present
- in_a / in_b  in  DATA_W  operand value (used when *_rdy=1)
- in_a_tag / in_b_tag  in  ROB_W  producing ROB tag (used when *_rdy=0)
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  ROB_W  broadcast ROB tag
- cdb_data  in  DATA_W  broadcast value
- alu_ena  out  1  issue strobe to ALU, one cycle per op
- alu_op  out  OP_W  issued operation
- alu_a / alu_b  out  DATA_W  issued operands
- alu_rob_tag  out  ROB_W  issued ROB tag

## Operation
- Entry state: busy, op, rob_tag, a/b value, a/b ready, a/b tag.
- Allocate: in_valid && in_ready && !flush. Write to the lowest-index free entry.
- Allocate-time bypass: if an operand is not ready and cdb_valid && cdb_tag == its tag in the same cycle, store cdb_data and mark it ready.
- Wakeup: every busy entry with a non-ready operand whose tag matches a valid CDB captures cdb_data and sets ready. Both operands may wake on the same broadcast.
- Eligibility: busy && a_ready && b_ready, taken from registered state only. An operand woken at edge k is eligible for selection in the cycle after edge k.
- Select: choose one eligible entry per cycle (priority set by Configuration). At the next edge, drive alu_* from the selected entry, set alu_ena=1, and clear its busy bit. If nothing is eligible, alu_ena=0 and the other alu_* outputs hold their previous values.
- A freed slot is reallocatable from the following cycle. in_ready is derived from registered busy bits only, so there is no same-cycle free/allocate path.
- in_ready = 0 iff all DEPTH entries are busy. in_valid while in_ready=0 is ignored; dispatch must hold the op.
- Flush: at the edge, clear all busy bits and alu_ena. This discards any allocate, wakeup or issue in that cycle.
- Reset: all busy=0, alu_ena=0, alu_op=0, alu_a=0, alu_b=0, alu_rob_tag=0, in_ready=1.

## Timing
- Accept edge k with both operands ready: alu_ena=1 after edge k+1 (1-cycle minimum latency).
- Operand woken by CDB at edge k: earliest issue after edge k+1.
- Throughput: one issue per cycle, sustained.
- The ALU result is combinational from the alu_* registers, so result and tag are valid in the same cycle alu_ena=1.
- Simultaneous allocate + issue + wakeup in one cycle: all three take effect at the same edge, with independent entries.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous); all entries are lost.

## Configuration
- ALU_RS_AGE_PRIO_EN defined: oldest-first select using a DEPTH×DEPTH age matrix. The row is set on allocate and column bits clear on free. The oldest eligible entry issues regardless of index.
- ALU_RS_AGE_PRIO_EN undefined: the lowest-index eligible entry issues. There is no age matrix; starvation under continuous low-index readiness is accepted.

## Test plan
- Reset, then allocate ADD a=5 b=7 (both ready) at edge 1 -> after edge 2: alu_ena=1, alu_op=ADD, alu_a=5, alu_b=7, tag as given; after edge 3: alu_ena=0.
- Allocate SUB with b pending tag 3, a=10 -> no issue. Then CDB tag 3 data 4 -> next cycle alu_ena=1, alu_a=10, alu_b=4.
- Allocate with a pending tag 6 while the same cycle carries CDB tag 6 data 0x55 -> entry issues with alu_a=0x55 one cycle later (bypass).
- Allocate 8 ops with unready operands -> in_ready=0 after the 8th; a 9th in_valid is ignored. Wake one entry -> it issues and in_ready=1 the cycle after.
- With the macro defined: allocate X (slot 1), then Y (slot 0), wake both together -> X issues first. Without the macro -> Y issues first.
- Flush with 3 busy entries and an eligible entry -> next cycle alu_ena=0, in_ready=1, and a later CDB match causes no issue.
